// File: rtl/video_timing_pkg.sv
// Package: video_timing_pkg
// Purpose: shared types and presets for the raster timing generator.
//   timing_axis_t  - one axis of raster timing (active, front porch, sync,
//                    back porch), in pixels for H or lines for V
//   H_640 / V_480  - the 640x480@60 preset
//   axis_total()   - total length of one axis (sum of all four regions)
package video_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_axis_t;

  localparam timing_axis_t H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_axis_t V_480 = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int axis_total(timing_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// Module: timing_axis_counter
// Purpose: one raster axis counter. Counts 0..TOTAL-1 on each step and
//   decodes the active and sync windows of the current count.
// Ports:
//   clk    in   pixel clock
//   rst    in   synchronous active-high reset, clears the count
//   step   in   advance the count by one (wraps at TOTAL-1)
//   cnt    out  current position on this axis
//   wrap   out  count is at TOTAL-1 (next step returns it to 0)
//   active out  cnt lies in the visible region
//   sync   out  cnt lies in the sync window (polarity not applied)
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter timing_axis_t AXIS = H_640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [11:0] cnt,
  output logic        wrap,
  output logic        active,
  output logic        sync
);

  localparam int TOTAL = axis_total(AXIS);

  // Region boundaries held one bit wider than cnt so a 4096-long axis
  // still compares correctly.
  localparam logic [11:0] LAST       = 12'(TOTAL - 1);
  localparam logic [12:0] ACT_END    = 13'(AXIS.active);
  localparam logic [12:0] SYNC_START = 13'(AXIS.active + AXIS.fp);
  localparam logic [12:0] SYNC_END   = 13'(AXIS.active + AXIS.fp + AXIS.sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 12'd1;
    end
  end

  assign wrap   = (cnt == LAST);
  assign active = ({1'b0, cnt} < ACT_END);
  assign sync   = ({1'b0, cnt} >= SYNC_START) && ({1'b0, cnt} < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Module: video_timing_gen
// Purpose: raster timing generator feeding the TMDS encoders. Walks the
//   H/V counters through active and blanking regions and produces VDE, the
//   control data {vsync,hsync} and the matching pixel coordinates.
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset (overrides ce)
//   ce           in   pixel enable; when low everything holds
//   pix_req      out  counters are on an active pixel; that pixel is shown
//                     on VDE/x/y after the next ce edge
//   VDE          out  video data enable
//   CD           out  {vsync, hsync} with polarity applied
//   x, y         out  coordinates of the pixel marked by VDE/CD
//   line_start   out  pulse with x==0
//   frame_start  out  pulse with x==0 && y==0
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic        pix_req,
  output logic        VDE,
  output logic [1:0]  CD,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam timing_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      axis_total(H_AXIS) > 4096 || axis_total(V_AXIS) > 4096) begin : g_param_check
    $fatal(1, "video_timing_gen: illegal timing parameters");
  end

  logic [11:0] h_cnt, v_cnt;
  logic        h_wrap, h_active, h_sync;
  logic        v_active, v_sync;
  // The vertical wrap is implicit in the counter itself; nothing here needs it.
  logic        v_wrap_unused;

  timing_axis_counter #(.AXIS(H_AXIS)) u_h_counter (
    .clk    (clk),
    .rst    (rst),
    .step   (ce),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // The line counter advances on the same edge that wraps the pixel counter,
  // so (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in one cycle.
  timing_axis_counter #(.AXIS(V_AXIS)) u_v_counter (
    .clk    (clk),
    .rst    (rst),
    .step   (ce & h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  assign pix_req = h_active & v_active;

  // Output stage: loads the decode of the current counters, so every output
  // lags pix_req by exactly one ce edge and all outputs stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      VDE         <= 1'b0;
      CD          <= {~VS_POL, ~HS_POL};
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      VDE         <= pix_req;
      CD[0]       <= h_sync ? HS_POL : ~HS_POL;
      CD[1]       <= v_sync ? VS_POL : ~VS_POL;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == 12'd0);
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench: tb_video_timing_gen
// Purpose: directed checks of the raster generator on a reduced raster
//   (16 x 11 total, 8 x 6 visible) so whole frames fit in a short run.
//   A second instance with both sync polarities inverted shares the inputs.
//   H: active 0..7, FP 8..9, sync 10..12, BP 13..15
//   V: active 0..5, FP 6,    sync 7..8,   BP 9..10   -> frame = 176 cycles
module tb_video_timing_gen;

  localparam int HT = 16;
  localparam int VT = 11;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;

  logic        pix_req, vde, line_start, frame_start;
  logic [1:0]  cd;
  logic [11:0] x, y;

  logic        inv_pix_req, inv_vde, inv_line_start, inv_frame_start;
  logic [1:0]  inv_cd;
  logic [11:0] inv_x, inv_y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .ce(ce),
    .pix_req(pix_req), .VDE(vde), .CD(cd), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_inv (
    .clk(clk), .rst(rst), .ce(ce),
    .pix_req(inv_pix_req), .VDE(inv_vde), .CD(inv_cd), .x(inv_x), .y(inv_y),
    .line_start(inv_line_start), .frame_start(inv_frame_start)
  );

  // Raster model: expected decode of frame position p (0..FT-1).
  function automatic logic m_active(int p);
    return ((p % HT) < 8) && ((p / HT) < 6);
  endfunction

  function automatic logic [1:0] m_cd_low(int p);
    logic hs, vs;
    hs = ((p % HT) >= 10) && ((p % HT) <= 12);
    vs = ((p / HT) >= 7) && ((p / HT) <= 8);
    return {~vs, ~hs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with ce high, then the first enabled edge shows pixel (0,0).
  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (3) tick();
    checks++;
    if ({vde, cd, x, y, line_start, frame_start} !== {1'b0, 2'b11, 12'd0, 12'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got vde=%b cd=%b x=%0d y=%0d ls=%b fs=%b, want 0 11 0 0 0 0",
               vde, cd, x, y, line_start, frame_start);
    end
    checks++;
    if (inv_cd !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_cd_inv: got %b want 00", inv_cd);
    end
    checks++;
    if (pix_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pix_req: got %b want 1", pix_req);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({vde, x, y, line_start, frame_start} !== {1'b1, 12'd0, 12'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL first_pixel: got vde=%b x=%0d y=%0d ls=%b fs=%b, want 1 0 0 1 1",
               vde, x, y, line_start, frame_start);
    end
  endtask

  // One full frame with ce held high, starting from the (0,0) output left by
  // test_reset. Checks every cycle plus frame-level counts and the wrap.
  task automatic test_frame();
    int vde_cnt = 0;
    int ls_cnt  = 0;
    int fs_cnt  = 0;
    ce = 1'b1;
    for (int p = 0; p < FT; p++) begin
      checks++;
      if ({y, x} !== {12'(p / HT), 12'(p % HT)}) begin
        failures++;
        $display("[TB] FAIL frame_xy: got (%0d,%0d) want (%0d,%0d)", x, y, p % HT, p / HT);
      end
      checks++;
      if (vde !== m_active(p)) begin
        failures++;
        $display("[TB] FAIL frame_vde at (%0d,%0d): got %b want %b", p % HT, p / HT, vde, m_active(p));
      end
      checks++;
      if (cd !== m_cd_low(p) || inv_cd !== ~m_cd_low(p)) begin
        failures++;
        $display("[TB] FAIL frame_cd at (%0d,%0d): got %b/%b want %b/%b",
                 p % HT, p / HT, cd, inv_cd, m_cd_low(p), ~m_cd_low(p));
      end
      checks++;
      if (pix_req !== m_active((p + 1) % FT)) begin
        failures++;
        $display("[TB] FAIL frame_pix_req at pos %0d: got %b want %b", p, pix_req, m_active((p + 1) % FT));
      end
      checks++;
      if (line_start !== ((p % HT) == 0) || frame_start !== (p == 0)) begin
        failures++;
        $display("[TB] FAIL frame_pulses at pos %0d: got ls=%b fs=%b", p, line_start, frame_start);
      end
      vde_cnt += int'(vde);
      ls_cnt  += int'(line_start);
      fs_cnt  += int'(frame_start);
      tick();
    end
    checks++;
    if ({vde_cnt, ls_cnt, fs_cnt} !== {32'd48, 32'd11, 32'd1}) begin
      failures++;
      $display("[TB] FAIL frame_counts: got vde=%0d ls=%0d fs=%0d want 48 11 1", vde_cnt, ls_cnt, fs_cnt);
    end
    // 176 edges after the previous frame_start: wrapped from (15,10) to (0,0).
    checks++;
    if ({frame_start, line_start, vde, x, y} !== {1'b1, 1'b1, 1'b1, 12'd0, 12'd0}) begin
      failures++;
      $display("[TB] FAIL frame_wrap: got fs=%b ls=%b vde=%b x=%0d y=%0d want 1 1 1 0 0",
               frame_start, line_start, vde, x, y);
    end
  endtask

  // Random ce gaps: outputs must follow the ce=1 edge count only.
  task automatic test_ce_gaps();
    int n = 0;
    int p;
    logic ce_now;
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      ce_now = 1'($urandom_range(0, 1));
      ce = ce_now;
      tick();
      if (ce_now) n++;
      checks++;
      if (pix_req !== m_active(n % FT)) begin
        failures++;
        $display("[TB] FAIL gap_pix_req after %0d edges: got %b want %b", n, pix_req, m_active(n % FT));
      end
      if (n == 0) begin
        checks++;
        if ({vde, cd, x, y, line_start, frame_start} !== {1'b0, 2'b11, 12'd0, 12'd0, 1'b0, 1'b0}) begin
          failures++;
          $display("[TB] FAIL gap_idle: outputs left reset state before first ce edge");
        end
      end else begin
        p = (n - 1) % FT;
        checks++;
        if ({vde, cd, y, x, line_start, frame_start} !==
            {m_active(p), m_cd_low(p), 12'(p / HT), 12'(p % HT), 1'((p % HT) == 0), 1'(p == 0)}) begin
          failures++;
          $display("[TB] FAIL gap_outputs edge %0d: got vde=%b cd=%b x=%0d y=%0d ls=%b fs=%b want pos (%0d,%0d)",
                   n, vde, cd, x, y, line_start, frame_start, p % HT, p / HT);
        end
      end
    end
  endtask

  // Reset mid-frame with ce low: reset still wins, frame restarts at (0,0).
  task automatic test_midframe_reset();
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    rst = 1'b0;
    ce  = 1'b1;
    repeat (3 * HT + 5 + 1) tick();
    checks++;
    if ({vde, x, y} !== {1'b1, 12'd5, 12'd3}) begin
      failures++;
      $display("[TB] FAIL mid_position: got vde=%b x=%0d y=%0d want 1 5 3", vde, x, y);
    end
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    checks++;
    if ({vde, cd, inv_cd, x, y, line_start, frame_start} !==
        {1'b0, 2'b11, 2'b00, 12'd0, 12'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL mid_reset: got vde=%b cd=%b inv_cd=%b x=%0d y=%0d ls=%b fs=%b",
               vde, cd, inv_cd, x, y, line_start, frame_start);
    end
    rst = 1'b0;
    ce  = 1'b1;
    tick();
    checks++;
    if ({vde, x, y, line_start, frame_start, inv_frame_start} !==
        {1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_restart: got vde=%b x=%0d y=%0d ls=%b fs=%b inv_fs=%b",
               vde, x, y, line_start, frame_start, inv_frame_start);
    end
    repeat (HT) tick();
    checks++;
    if ({x, y, line_start, frame_start} !== {12'd0, 12'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL mid_next_line: got x=%0d y=%0d ls=%b fs=%b want 0 1 1 0",
               x, y, line_start, frame_start);
    end
  endtask

  initial begin
    $display("[TB] starting video_timing_gen bench");
    test_reset();
    test_frame();
    test_ce_gaps();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
